// File: rtl/moore_seq_pkg.sv
// rtl/moore_seq_pkg.sv - shared defaults and elaboration-time pattern helpers for moore_seq_detect
package moore_seq_pkg;

    localparam int         DEF_PAT_W   = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1011;
    localparam int         DEF_CNT_W   = 8;

    function automatic int state_w(input int pw);
        return $clog2(pw + 1);
    endfunction

    // Bit i of the pattern counted from the first bit received (MSB).
    function automatic logic pat_bit(input logic [15:0] p, input int pw, input int i);
        return 1'(p >> (pw - 1 - i));
    endfunction

    // Matched-length after k matched bits are followed by bit b; the longest
    // pattern prefix that is a suffix of that string wins.
    function automatic int kmp_next(input logic [15:0] p, input int pw, input int k, input logic b);
        int   res;
        logic ok;
        logic sb;
        res = 0;
        for (int len = 1; len <= k + 1; len++) begin
            ok = 1'b1;
            for (int i = 0; i < len; i++) begin
                sb = (k + 1 - len + i < k) ? pat_bit(p, pw, k + 1 - len + i) : b;
                if (pat_bit(p, pw, i) != sb) ok = 1'b0;
            end
            if (ok) res = len;
        end
        return res;
    endfunction

    // Longest proper border of the whole pattern.
    function automatic int kmp_border(input logic [15:0] p, input int pw);
        int   res;
        logic ok;
        res = 0;
        for (int len = 1; len < pw; len++) begin
            ok = 1'b1;
            for (int i = 0; i < len; i++) begin
                if (pat_bit(p, pw, i) != pat_bit(p, pw, pw - len + i)) ok = 1'b0;
            end
            if (ok) res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous reset
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/moore_seq_detect.sv
// rtl/moore_seq_detect.sv - Moore serial pattern detector with KMP fallback and match counter
module moore_seq_detect
    import moore_seq_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter int               CNT_W   = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       x,
    input  logic                       overlap,
    output logic                       y,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [state_w(PAT_W)-1:0]  state
);

    localparam int SW     = state_w(PAT_W);
    localparam int BORDER = kmp_border(16'(PATTERN), PAT_W);

    logic [PAT_W-1:0][SW-1:0] tab0;
    logic [PAT_W-1:0][SW-1:0] tab1;
    logic [SW-1:0]            base;
    logic [SW-1:0]            state_d;
    logic                     hit;

    // Transition table is fixed at elaboration; rows cover S0..S(PAT_W-1).
    for (genvar k = 0; k < PAT_W; k++) begin : g_row
        localparam int N0 = kmp_next(16'(PATTERN), PAT_W, k, 1'b0);
        localparam int N1 = kmp_next(16'(PATTERN), PAT_W, k, 1'b1);
        assign tab0[k] = SW'(N0);
        assign tab1[k] = SW'(N1);
    end

    always_comb begin
        base    = state;
        state_d = state;
        // A full match restarts from the border (overlap) or from scratch.
        if (state == SW'(PAT_W)) begin
            base = overlap ? SW'(BORDER) : '0;
        end
        if (en) begin
            for (int k = 0; k < PAT_W; k++) begin
                if (base == SW'(k)) state_d = x ? tab1[k] : tab0[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
        end else begin
            state <= state_d;
        end
    end

    assign y   = (state == SW'(PAT_W));
    assign hit = en && (state_d == SW'(PAT_W));

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .q   (match_cnt)
    );

endmodule

// File: tb/tb_moore_seq_detect.sv
// tb/tb_moore_seq_detect.sv - scoreboard bench for moore_seq_detect against a sliding-window model
module tb_moore_seq_detect;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic x = 1'b0;
    logic overlap = 1'b1;

    logic [2:0] st0; logic y0; logic [7:0] c0;
    logic [2:0] st1; logic y1; logic [1:0] c1;
    logic [1:0] st2; logic y2; logic [3:0] c2;

    always #5 clk = ~clk;

    moore_seq_detect dut0 (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap),
        .y(y0), .match_cnt(c0), .state(st0)
    );

    moore_seq_detect #(.CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap),
        .y(y1), .match_cnt(c1), .state(st1)
    );

    moore_seq_detect #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap),
        .y(y2), .match_cnt(c2), .state(st2)
    );

    typedef struct {
        int s0; int s1; int s2;
        int c0; int c1; int c2;
    } exp_t;

    exp_t expq[$];
    int total = 0;
    int bad = 0;

    logic [15:0] mpat [3];
    int          mpw  [3];
    int          mmax [3];
    logic [15:0] mwin [3];
    int          mlen [3];
    int          mst  [3];
    int          mcnt [3];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Longest pattern prefix equal to the most recent bits seen since the last restart.
    function automatic int longest(input int d);
        int res;
        logic ok;
        res = 0;
        for (int len = 1; len <= mpw[d] && len <= mlen[d]; len++) begin
            ok = 1'b1;
            for (int i = 0; i < len; i++) begin
                if (mwin[d][len - 1 - i] != mpat[d][mpw[d] - 1 - i]) ok = 1'b0;
            end
            if (ok) res = len;
        end
        return res;
    endfunction

    task automatic step(input logic r, input logic e, input logic xi, input logic ov);
        exp_t t;
        @(negedge clk);
        rst = r; en = e; x = xi; overlap = ov;
        for (int d = 0; d < 3; d++) begin
            if (r) begin
                mlen[d] = 0; mst[d] = 0; mcnt[d] = 0;
            end else if (e) begin
                if (mst[d] == mpw[d] && !ov) mlen[d] = 0;
                mwin[d] = {mwin[d][14:0], xi};
                mlen[d] = (mlen[d] < 16) ? mlen[d] + 1 : 16;
                mst[d] = longest(d);
                if (mst[d] == mpw[d] && mcnt[d] < mmax[d]) mcnt[d]++;
            end
        end
        t.s0 = mst[0]; t.s1 = mst[1]; t.s2 = mst[2];
        t.c0 = mcnt[0]; t.c1 = mcnt[1]; t.c2 = mcnt[2];
        expq.push_back(t);
    endtask

    task automatic bits(input string s, input logic ov);
        for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i] == "1", ov);
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    initial begin : monitor
        exp_t t;
        forever begin
            @(posedge clk);
            #2;
            if (expq.size() > 0) begin
                t = expq.pop_front();
                chk("st0", int'(st0), t.s0);
                chk("y0", int'(y0), int'(t.s0 == 4));
                chk("cnt0", int'(c0), t.c0);
                chk("st1", int'(st1), t.s1);
                chk("y1", int'(y1), int'(t.s1 == 4));
                chk("cnt1", int'(c1), t.c1);
                chk("st2", int'(st2), t.s2);
                chk("y2", int'(y2), int'(t.s2 == 3));
                chk("cnt2", int'(c2), t.c2);
            end
        end
    end

    initial begin : driver
        logic ov;
        mpat[0] = 16'b1011; mpw[0] = 4; mmax[0] = 255;
        mpat[1] = 16'b1011; mpw[1] = 4; mmax[1] = 3;
        mpat[2] = 16'b111;  mpw[2] = 3; mmax[2] = 15;
        for (int d = 0; d < 3; d++) begin
            mwin[d] = '0; mlen[d] = 0; mst[d] = 0; mcnt[d] = 0;
        end

        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        settle();
        chk("reset_state", int'(st0), 0);
        chk("reset_y", int'(y0), 0);
        chk("reset_cnt", int'(c0), 0);

        bits("1011", 1'b1);
        settle();
        chk("ov_first_y", int'(y0), 1);
        bits("011", 1'b1);
        settle();
        chk("ov_second_y", int'(y0), 1);
        chk("ov_cnt", int'(c0), 2);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        bits("1011011", 1'b0);
        settle();
        chk("nov_state", int'(st0), 1);
        chk("nov_y", int'(y0), 0);
        chk("nov_cnt", int'(c0), 1);

        step(1'b1, 1'b0, 1'b0, 1'b1);
        bits("1010", 1'b1);
        settle();
        chk("kmp_fallback", int'(st0), 2);
        bits("11", 1'b1);
        settle();
        chk("kmp_y", int'(y0), 1);
        chk("kmp_cnt", int'(c0), 1);

        step(1'b1, 1'b0, 1'b0, 1'b1);
        bits("1011", 1'b1);
        settle();
        chk("hold_y0", int'(y0), 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'($urandom_range(1)), 1'b1);
            settle();
            chk("hold_y", int'(y0), 1);
            chk("hold_cnt", int'(c0), 1);
        end

        step(1'b1, 1'b0, 1'b0, 1'b1);
        bits("101", 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        bits("1", 1'b1);
        settle();
        chk("midrst_state", int'(st0), 1);
        chk("midrst_y", int'(y0), 0);
        chk("midrst_cnt", int'(c0), 0);

        step(1'b1, 1'b0, 1'b0, 1'b1);
        bits("1011011011011011", 1'b1);
        settle();
        chk("sat_cnt", int'(c1), 3);
        chk("unsat_cnt", int'(c0), 5);

        ov = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(19) == 0) ov = ~ov;
            step($urandom_range(99) == 0, $urandom_range(3) != 0,
                 $urandom_range(9) < 6, ov);
        end

        for (int i = 0; i < 10 && expq.size() != 0; i++) @(posedge clk);
        #3;
        chk("drain", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
